dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Data-memory access controller directly upstream of the mem stage. It takes load/store requests from the EX/MEM boundary and runs them on a req/ack data-RAM bus. It performs RV32I byte-lane alignment, byte enables and load sign/zero extension, and produces the 32-bit load word consumed by mem as mem_rdata_i. It stalls the pipeline while a bus transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max BUS-state cycles without bus_ack_i before abort (1..65535)
CNT_WIDTH, 16, width of timeout counter

Ports:
clk  input  1  system clock, all state on rising edge
arst_n  input  1  reset: synchronous, active-low
req_rena_i  input  1  load request
req_wena_i  input  1  store request
req_addr_i  input  32  byte address (rs1+imm)
req_wdata_i  input  32  store data (rs2), data in bits [7:0]/[15:0]/[31:0]
funct3_i  input  3  access type: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
stall_o  output  1  hold IF/ID/EX/MEM pipeline registers
rdata_o  output  32  extended load result (to mem.mem_rdata_i)
rdata_valid_o  output  1  one-cycle pulse, rdata_o updated by a completed load
misalign_o  output  1  one-cycle pulse, misaligned access dropped
err_o  output  1  one-cycle pulse, illegal funct3 or bus timeout
bus_req_o  output  1  bus request, held until ack
bus_we_o  output  1  1 = write
bus_addr_o  output  32  word address, {req_addr_i[31:2],2'b00}
bus_wdata_o  output  32  lane-replicated store data
bus_be_o  output  4  byte enables, all 1 for reads
bus_ack_i  input  1  transaction complete; read data valid same cycle
bus_rdata_i  input  32  read word

Behaviour:
- Reset (arst_n=0 at a clk edge): state IDLE, counter 0, and every output register 0: rdata_o, rdata_valid_o, misalign_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o. stall_o=0.
- Reset mid-transaction: bus_req_o drops on the reset edge, with no completion pulse. bus_ack_i is ignored in IDLE and DONE.
- FSM states: IDLE, BUS, DONE.
- IDLE, request present (req_rena_i|req_wena_i): capture the request. If both are high, the store wins and the load is ignored.
  - Legal and aligned -> BUS. Register bus_req_o=1, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o and clear the counter.
  - Misaligned -> DONE with misalign_o=1 and no bus access. Misaligned means: halfword with addr[0]=1, or word with addr[1:0]!=00.
  - Illegal funct3 -> DONE with err_o=1 and no bus access. Illegal for loads: 011/110/111. Illegal for stores: any value >010.
- BUS:
  - Bus outputs are held stable.
  - bus_ack_i=1 -> DONE and deassert bus_req_o. On a load, register the extended rdata_o and set rdata_valid_o=1.
  - bus_ack_i=0 -> counter+1. When the counter reaches TIMEOUT_CYCLES-1 with no ack -> DONE, deassert bus_req_o, err_o=1, rdata_o=0.
- DONE: exactly one cycle, then unconditionally IDLE. It never re-accepts: the request inputs still show the completed instruction this cycle.
- stall_o (combinational) = (IDLE & request present) | BUS. It is 0 in DONE, so the pipeline advances at the end of DONE.
- Latency: request cycle 0 -> bus_req_o cycle 1. With ack in cycle k, DONE is cycle k+1. Minimum 2 stall cycles; 1 stall cycle for a dropped access.
- Pulses: rdata_valid_o, misalign_o and err_o are high only in the DONE cycle. rdata_o holds its value until the next completed load, misaligned access or error (all of which write 0 or new data).
- Store lanes:
  - SB: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, be=addr[1]?1100:0011.
  - SW: wdata=d, be=1111.
- Load extraction: byte b=bus_rdata_i[8*addr[1:0]+:8]; half h=bus_rdata_i[16*addr[1]+:16].
  - LB = sign-extend b.
  - LBU = zero-extend b.
  - LH = sign-extend h.
  - LHU = zero-extend h.
  - LW = word.

Test Plan:
- LW addr 0x100, ack in cycle 1, bus_rdata_i=0xDEADBEEF -> bus_addr_o=0x100, be=1111; stall 2 cycles; DONE: rdata_o=0xDEADBEEF, rdata_valid_o pulse.
- LB addr 0x103 and LBU addr 0x103, bus_rdata_i=0x80FF0011 -> LB gives rdata_o=0xFFFFFF80; LBU gives 0x00000080. LH 0x102 gives 0xFFFF80FF.
- SB addr 0x205 d=0x000000A5 -> bus_addr_o=0x204, be=0010, wdata=0xA5A5A5A5, we=1. SH addr 0x206 d=0x1234 -> be=1100, wdata=0x12341234.
- Ack delayed 5 cycles -> bus_req_o and bus outputs stable throughout; stall_o high 6 cycles; single rdata_valid_o pulse.
- LW addr 0x102 -> no bus_req_o, misalign_o pulse, rdata_o=0, 1 stall cycle. funct3=011 load -> err_o pulse, no bus_req_o.
- TIMEOUT_CYCLES=4, ack never given -> bus_req_o high 4 cycles then drops, err_o pulse. Separately, arst_n=0 mid-BUS -> next edge all outputs 0, a later ack is ignored.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller between EX/MEM and the mem stage.
// Turns RV32I load/store requests into single req/ack data-RAM transactions,
// handling byte-lane alignment, byte enables and load sign/zero extension,
// and stalls the pipeline while a transaction is outstanding.
//
// Ports:
//   clk, arst_n          clock; synchronous active-low reset
//   req_rena_i/wena_i    load / store request (store wins if both)
//   req_addr_i           byte address
//   req_wdata_i          store data, right-aligned
//   funct3_i             RV32I access type
//   stall_o              hold pipeline registers
//   rdata_o              extended load result
//   rdata_valid_o        one-cycle pulse: rdata_o updated by a load
//   misalign_o, err_o    one-cycle pulses: access dropped / illegal or timeout
//   bus_*                req/ack data-RAM bus (word address, byte enables)
module dmem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        req_rena_i,
    input  logic        req_wena_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  funct3_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [1:0]           addr_lo_q, addr_lo_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rdata_valid_q, rdata_valid_d;
    logic                 misalign_q, misalign_d;
    logic                 err_q, err_d;
    logic                 bus_req_q, bus_req_d;
    logic                 bus_we_q, bus_we_d;
    logic [31:0]          bus_addr_q, bus_addr_d;
    logic [31:0]          bus_wdata_q, bus_wdata_d;
    logic [3:0]           bus_be_q, bus_be_d;

    logic        req_any;
    logic        illegal;
    logic        misaligned;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign req_any = req_rena_i | req_wena_i;

    // Request decode (store takes priority when both enables are set)
    always_comb begin
        if (req_wena_i) begin
            illegal = (funct3_i > 3'b010);
        end else begin
            illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
        end
        misaligned = ((funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        case (funct3_i[1:0])
            2'b00: begin
                lane_wdata = {4{req_wdata_i[7:0]}};
                lane_be    = 4'b0001 << req_addr_i[1:0];
            end
            2'b01: begin
                lane_wdata = {2{req_wdata_i[15:0]}};
                lane_be    = req_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_wdata = req_wdata_i;
                lane_be    = 4'b1111;
            end
        endcase
    end

    // Load extraction uses the captured offset/type, not the live request
    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = bus_rdata_i[7:0];
            2'd1:    ld_byte = bus_rdata_i[15:8];
            2'd2:    ld_byte = bus_rdata_i[23:16];
            default: ld_byte = bus_rdata_i[31:24];
        endcase
        ld_half = addr_lo_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        funct3_d      = funct3_q;
        addr_lo_d     = addr_lo_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        misalign_d    = 1'b0;
        err_d         = 1'b0;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_be_d      = bus_be_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    funct3_d  = funct3_i;
                    addr_lo_d = req_addr_i[1:0];
                    if (illegal) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (misaligned) begin
                        state_d    = S_DONE;
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                    end else begin
                        state_d     = S_BUS;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_wena_i;
                        bus_addr_d  = {req_addr_i[31:2], 2'b00};
                        bus_wdata_d = lane_wdata;
                        bus_be_d    = req_wena_i ? lane_be : 4'b1111;
                    end
                end
            end
            S_BUS: begin
                if (bus_ack_i) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        rdata_d       = ld_ext;
                        rdata_valid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                // DONE: request inputs still show the finished access; never re-accept
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            funct3_q      <= '0;
            addr_lo_q     <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            err_q         <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_be_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            funct3_q      <= funct3_d;
            addr_lo_q     <= addr_lo_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            misalign_q    <= misalign_d;
            err_q         <= err_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_be_q      <= bus_be_d;
        end
    end

    assign stall_o       = ((state_q == S_IDLE) && req_any) || (state_q == S_BUS);
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign misalign_o    = misalign_q;
    assign err_o         = err_q;
    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign bus_be_o      = bus_be_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: directed vector table, reset/ack-ignore sequence,
// and randomized transactions against a behavioural reference model.
module tb_dmem_ctrl;

    localparam int TO    = 8;
    localparam int LIMIT = TO + 4;

    logic        clk;
    logic        arst_n;
    logic        req_rena_i, req_wena_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [2:0]  funct3_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, misalign_o, err_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_rena_i(req_rena_i), .req_wena_i(req_wena_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .funct3_i(funct3_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .misalign_o(misalign_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rena, wena;
        logic [31:0] addr, wdata;
        logic [2:0]  f3;
        int          ack_at;   // cycle ack is driven; 0 = never
        logic [31:0] word;
    } txn_t;

    typedef struct {
        int          stall, reqc;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          nv, nmis, nerr;
        logic [31:0] rdata;
        logic        stable, hung;
    } obs_t;

    typedef struct {
        logic        rena, wena;
        logic [31:0] addr, wdata;
        logic [2:0]  f3;
        int          ack_at;
        logic [31:0] word;
        int          stall, reqc;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwdata;
        int          v, mis, err;
        logic [31:0] rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: derives the whole transaction outcome from the access rules
    function automatic obs_t model(input txn_t t, input logic [31:0] prev);
        obs_t        e;
        logic        st, bad, mis;
        int          nb, off;
        logic [31:0] mask, sh, v;
        st  = t.wena;
        off = int'(t.addr[1:0]);
        nb  = 1 << t.f3[1:0];
        bad = st ? (t.f3 > 3'd2) : (t.f3 == 3'd3 || t.f3 == 3'd6 || t.f3 == 3'd7);
        mis = !bad && ((off % nb) != 0);
        e = '{stall: 1, reqc: 0, addr: 0, we: st, be: 0, wdata: 0, nv: 0, nmis: 0,
              nerr: 0, rdata: prev, stable: 1'b1, hung: 1'b0};
        if (bad) begin
            e.nerr = 1; e.rdata = 0;
        end else if (mis) begin
            e.nmis = 1; e.rdata = 0;
        end else begin
            e.addr = t.addr & 32'hFFFF_FFFC;
            e.be   = st ? 4'(((1 << nb) - 1) << off) : 4'hF;
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = t.wdata[8*(i % nb) +: 8];
            if (t.ack_at != 0 && t.ack_at <= TO) begin
                e.stall = t.ack_at + 1;
                e.reqc  = t.ack_at;
                if (!st) begin
                    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
                    sh   = t.word >> (8 * off);
                    v    = sh & mask;
                    if (!t.f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
                    e.nv = 1; e.rdata = v;
                end
            end else begin
                e.stall = TO + 1; e.reqc = TO; e.nerr = 1; e.rdata = 0;
            end
        end
        return e;
    endfunction

    // Entered and left at posedge+1; request held until DONE (stall low after cycle 0)
    task automatic run_txn(input txn_t t, output obs_t o);
        logic done;
        o = '{stall: 0, reqc: 0, addr: 0, we: 0, be: 0, wdata: 0, nv: 0, nmis: 0,
              nerr: 0, rdata: 0, stable: 1'b1, hung: 1'b0};
        req_rena_i = t.rena; req_wena_i = t.wena; req_addr_i = t.addr;
        req_wdata_i = t.wdata; funct3_i = t.f3;
        done = 1'b0;
        for (int cyc = 0; cyc < LIMIT && !done; cyc++) begin
            bus_ack_i   = (t.ack_at != 0 && cyc == t.ack_at);
            bus_rdata_i = bus_ack_i ? t.word : $urandom();
            @(negedge clk);
            if (stall_o) o.stall++;
            if (bus_req_o) begin
                if (o.reqc == 0) begin
                    o.addr = bus_addr_o; o.we = bus_we_o; o.be = bus_be_o; o.wdata = bus_wdata_o;
                end else if (bus_addr_o !== o.addr || bus_we_o !== o.we ||
                             bus_be_o !== o.be || bus_wdata_o !== o.wdata) begin
                    o.stable = 1'b0;
                end
                o.reqc++;
            end
            if (rdata_valid_o) o.nv++;
            if (misalign_o) o.nmis++;
            if (err_o) o.nerr++;
            if (cyc > 0 && !stall_o) begin
                done = 1'b1;
                o.rdata = rdata_o;
            end
            @(posedge clk); #1;
        end
        o.hung = !done;
        bus_ack_i = 1'b0; req_rena_i = 1'b0; req_wena_i = 1'b0;
    endtask

    task automatic compare(input string tag, input obs_t o, input obs_t e);
        check({tag, ".done"},   32'(o.hung), 32'(e.hung));
        check({tag, ".stall"},  o.stall, e.stall);
        check({tag, ".reqcyc"}, o.reqc, e.reqc);
        check({tag, ".valid"},  o.nv, e.nv);
        check({tag, ".misal"},  o.nmis, e.nmis);
        check({tag, ".err"},    o.nerr, e.nerr);
        check({tag, ".rdata"},  o.rdata, e.rdata);
        if (e.reqc != 0) begin
            check({tag, ".addr"},   o.addr, e.addr);
            check({tag, ".we"},     32'(o.we), 32'(e.we));
            check({tag, ".be"},     32'(o.be), 32'(e.be));
            check({tag, ".stable"}, 32'(o.stable), 32'(1));
            if (e.we) check({tag, ".wdata"}, o.wdata, e.wdata);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rdata"},   rdata_o, 0);
        check({tag, ".pulses"},  {29'b0, rdata_valid_o, misalign_o, err_o}, 0);
        check({tag, ".bus_req"}, {30'b0, bus_req_o, bus_we_o}, 0);
        check({tag, ".bus_addr"}, bus_addr_o, 0);
        check({tag, ".bus_wdata"}, bus_wdata_o, 0);
        check({tag, ".bus_be"},  32'(bus_be_o), 0);
        check({tag, ".stall"},   32'(stall_o), 0);
    endtask

    vec_t vecs[$];

    initial begin
        txn_t        t;
        obs_t        o, e;
        logic [31:0] model_rdata;
        int          sel;

        vecs.push_back('{1'b1, 1'b0, 32'h100, 32'h0, 3'd2, 1, 32'hDEADBEEF, 2, 1, 32'h100, 4'hF, 32'h0, 1, 0, 0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 1'b0, 32'h103, 32'h0, 3'd0, 1, 32'h80FF0011, 2, 1, 32'h100, 4'hF, 32'h0, 1, 0, 0, 32'hFFFFFF80});
        vecs.push_back('{1'b1, 1'b0, 32'h103, 32'h0, 3'd4, 1, 32'h80FF0011, 2, 1, 32'h100, 4'hF, 32'h0, 1, 0, 0, 32'h00000080});
        vecs.push_back('{1'b1, 1'b0, 32'h102, 32'h0, 3'd1, 1, 32'h80FF0011, 2, 1, 32'h100, 4'hF, 32'h0, 1, 0, 0, 32'hFFFF80FF});
        vecs.push_back('{1'b0, 1'b1, 32'h205, 32'h000000A5, 3'd0, 1, 32'h0, 2, 1, 32'h204, 4'b0010, 32'hA5A5A5A5, 0, 0, 0, 32'hFFFF80FF});
        vecs.push_back('{1'b0, 1'b1, 32'h206, 32'h00001234, 3'd1, 1, 32'h0, 2, 1, 32'h204, 4'b1100, 32'h12341234, 0, 0, 0, 32'hFFFF80FF});
        vecs.push_back('{1'b1, 1'b0, 32'h100, 32'h0, 3'd2, 5, 32'h01234567, 6, 5, 32'h100, 4'hF, 32'h0, 1, 0, 0, 32'h01234567});
        vecs.push_back('{1'b1, 1'b0, 32'h102, 32'h0, 3'd2, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h100, 32'h0, 3'd3, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h102, 32'h0, 3'd5, 2, 32'h80FF0011, 3, 2, 32'h100, 4'hF, 32'h0, 1, 0, 0, 32'h000080FF});
        vecs.push_back('{1'b0, 1'b1, 32'h300, 32'hCAFEF00D, 3'd2, 1, 32'h0, 2, 1, 32'h300, 4'hF, 32'hCAFEF00D, 0, 0, 0, 32'h000080FF});
        vecs.push_back('{1'b1, 1'b0, 32'h400, 32'h0, 3'd2, 0, 32'h0, TO + 1, TO, 32'h400, 4'hF, 32'h0, 0, 0, 1, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 32'h001, 32'h0000005A, 3'd0, 1, 32'hFFFFFFFF, 2, 1, 32'h0, 4'b0010, 32'h5A5A5A5A, 0, 0, 0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h200, 32'h0, 3'd4, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h201, 32'h0, 3'd1, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h100, 32'h0, 3'd0, 1, 32'h0000007F, 2, 1, 32'h100, 4'hF, 32'h0, 1, 0, 0, 32'h0000007F});
        vecs.push_back('{1'b1, 1'b0, 32'h100, 32'h0, 3'd1, 1, 32'h00008001, 2, 1, 32'h100, 4'hF, 32'h0, 1, 0, 0, 32'hFFFF8001});

        arst_n = 1'b0; req_rena_i = 1'b0; req_wena_i = 1'b0; req_addr_i = '0;
        req_wdata_i = '0; funct3_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        foreach (vecs[i]) begin
            t = '{vecs[i].rena, vecs[i].wena, vecs[i].addr, vecs[i].wdata,
                  vecs[i].f3, vecs[i].ack_at, vecs[i].word};
            e = '{stall: vecs[i].stall, reqc: vecs[i].reqc, addr: vecs[i].baddr,
                  we: vecs[i].wena, be: vecs[i].be, wdata: vecs[i].bwdata,
                  nv: vecs[i].v, nmis: vecs[i].mis, nerr: vecs[i].err,
                  rdata: vecs[i].rdata, stable: 1'b1, hung: 1'b0};
            run_txn(t, o);
            compare($sformatf("vec%0d", i), o, e);
        end

        // Reset in the middle of a bus transaction, then a stray ack in IDLE
        req_rena_i = 1'b1; req_wena_i = 1'b0; req_addr_i = 32'h500; funct3_i = 3'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst.bus_req_before", 32'(bus_req_o), 1);
        arst_n = 1'b0; req_rena_i = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midrst");
        arst_n = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        check("stray_ack.valid", {30'b0, rdata_valid_o, err_o}, 0);
        check("stray_ack.rdata", rdata_o, 0);
        @(posedge clk); #1;
        check("stray_ack.bus_req", {30'b0, bus_req_o, stall_o}, 0);
        model_rdata = 32'h0;

        // Randomized transactions against the reference model
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 2);
            t.rena  = (sel != 1);
            t.wena  = (sel != 0);
            t.addr  = $urandom();
            t.wdata = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                sel  = $urandom_range(0, 4);
                t.f3 = (sel == 3) ? 3'd4 : (sel == 4) ? 3'd5 : 3'(sel);
            end else begin
                t.f3 = 3'($urandom_range(0, 7));
            end
            t.ack_at = $urandom_range(0, 10);
            t.word   = $urandom();
            e = model(t, model_rdata);
            run_txn(t, o);
            compare($sformatf("rnd%0d", n), o, e);
            model_rdata = e.rdata;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("idle.quiet", {28'b0, stall_o, bus_req_o, rdata_valid_o, err_o | misalign_o}, 0);
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
